// File: rtl/uart_tx_arbiter.sv
// Arbitrates a single UART transmitter between an echo FIFO (A, per byte) and a
// packetised report source (B, locked for a whole packet), round-robin per unit.
module uart_tx_arbiter #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TO_BITS        = 17
) (
    input  logic                 clk_50MHz,
    input  logic                 reset,
    input  logic                 a_valid,
    input  logic [DATA_BITS-1:0] a_data,
    output logic                 a_pop,
    input  logic                 b_req,
    input  logic [DATA_BITS-1:0] b_data,
    input  logic                 b_last,
    output logic                 b_ack,
    output logic                 tx_start,
    output logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done_tick,
    input  logic                 clr_err,
    output logic                 grant_a,
    output logic                 grant_b,
    output logic                 err_timeout,
    output logic                 err_abort
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

    localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT_CYCLES - 1);

    state_t               state, state_n;
    logic [TO_BITS-1:0]   cnt, cnt_n;
    logic                 lock, lock_n;
    logic                 last_b, last_b_n;
    logic                 cur_last, cur_last_n;
    logic                 a_pop_n, b_ack_n, tx_start_n;
    logic [DATA_BITS-1:0] tx_data_n;
    logic                 grant_a_n, grant_b_n;
    logic                 set_to, set_ab;
    logic                 lock_eff, pick_a, pick_b;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lock_n     = lock;
        last_b_n   = last_b;
        cur_last_n = cur_last;
        a_pop_n    = 1'b0;
        b_ack_n    = 1'b0;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        grant_a_n  = grant_a;
        grant_b_n  = grant_b;
        set_to     = 1'b0;
        set_ab     = 1'b0;
        lock_eff   = lock;
        pick_a     = 1'b0;
        pick_b     = 1'b0;

        case (state)
            IDLE: begin
                // An abandoned packet frees the transmitter for A in the same cycle.
                if (lock && !b_req) begin
                    set_ab    = 1'b1;
                    lock_n    = 1'b0;
                    grant_b_n = 1'b0;
                    lock_eff  = 1'b0;
                end
                if (!tx_busy) begin
                    if (lock_eff) begin
                        pick_b = 1'b1;
                    end else if (a_valid && b_req) begin
                        pick_a = last_b;
                        pick_b = !last_b;
                    end else begin
                        pick_a = a_valid;
                        pick_b = b_req;
                    end
                end
                if (pick_a) begin
                    state_n    = START;
                    tx_data_n  = a_data;
                    grant_a_n  = 1'b1;
                    grant_b_n  = 1'b0;
                    tx_start_n = 1'b1;
                    a_pop_n    = 1'b1;
                    last_b_n   = 1'b0;
                end else if (pick_b) begin
                    state_n    = START;
                    tx_data_n  = b_data;
                    grant_a_n  = 1'b0;
                    grant_b_n  = 1'b1;
                    tx_start_n = 1'b1;
                    b_ack_n    = 1'b1;
                    last_b_n   = 1'b1;
                    lock_n     = 1'b1;
                    cur_last_n = b_last;
                end
            end
            START: begin
                state_n = WAIT_DONE;
                cnt_n   = '0;
            end
            WAIT_DONE: begin
                if (tx_done_tick) begin
                    state_n   = IDLE;
                    grant_a_n = 1'b0;
                    if (grant_b && cur_last) begin
                        grant_b_n = 1'b0;
                        lock_n    = 1'b0;
                    end
                end else if (cnt == TO_LIMIT) begin
                    state_n   = IDLE;
                    set_to    = 1'b1;
                    grant_a_n = 1'b0;
                    grant_b_n = 1'b0;
                    lock_n    = 1'b0;
                end else begin
                    cnt_n = cnt + TO_BITS'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lock        <= 1'b0;
            last_b      <= 1'b1;
            cur_last    <= 1'b0;
            a_pop       <= 1'b0;
            b_ack       <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_a     <= 1'b0;
            grant_b     <= 1'b0;
            err_timeout <= 1'b0;
            err_abort   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lock        <= lock_n;
            last_b      <= last_b_n;
            cur_last    <= cur_last_n;
            a_pop       <= a_pop_n;
            b_ack       <= b_ack_n;
            tx_start    <= tx_start_n;
            tx_data     <= tx_data_n;
            grant_a     <= grant_a_n;
            grant_b     <= grant_b_n;
            err_timeout <= set_to | (err_timeout & ~clr_err);
            err_abort   <= set_ab | (err_abort & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed corner cases plus randomized traffic compared
// against an ordering model of the round-robin / packet-lock rules.
module tb_uart_tx_arbiter;

    localparam int DW = 8;
    localparam int TO = 50;

    logic          clk_50MHz = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid, b_req, b_last, tx_busy, tx_done_tick, clr_err;
    logic [DW-1:0] a_data, b_data, tx_data;
    logic          a_pop, b_ack, tx_start, grant_a, grant_b, err_timeout, err_abort;

    always #5 clk_50MHz = ~clk_50MHz;

    uart_tx_arbiter #(.DATA_BITS(DW), .TIMEOUT_CYCLES(TO), .TO_BITS(17)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset),
        .a_valid(a_valid), .a_data(a_data), .a_pop(a_pop),
        .b_req(b_req), .b_data(b_data), .b_last(b_last), .b_ack(b_ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick), .clr_err(clr_err),
        .grant_a(grant_a), .grant_b(grant_b),
        .err_timeout(err_timeout), .err_abort(err_abort)
    );

    int checks = 0;
    int errors = 0;

    bit             env_on;
    logic [7:0]     aq[$];
    logic [8:0]     bq[$];
    logic [11:0]    txlog[$];
    int             done_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({a_pop, b_ack, tx_start, grant_a, grant_b, err_timeout, err_abort, tx_data});
    endfunction

    task automatic env_sources();
        a_valid = (aq.size() > 0);
        a_data  = a_valid ? aq[0] : '0;
        b_req   = (bq.size() > 0);
        b_data  = b_req ? bq[0][7:0] : '0;
        b_last  = b_req ? bq[0][8] : 1'b0;
    endtask

    // One clock: sample just after the edge, then let the environment react.
    task automatic tick();
        @(posedge clk_50MHz);
        #1;
        check("grant_excl", 32'(grant_a & grant_b), 0);
        if (env_on) begin
            if (tx_done_tick) tx_done_tick = 1'b0;
            if (tx_start) begin
                txlog.push_back({grant_a, grant_b, a_pop, b_ack, tx_data});
                done_cnt = $urandom_range(1, 6);
            end else if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done_tick = 1'b1;
            end
            if (a_pop && aq.size() > 0) void'(aq.pop_front());
            if (b_ack && bq.size() > 0) void'(bq.pop_front());
            env_sources();
            tx_busy = ($urandom_range(0, 3) == 0);
        end
    endtask

    task automatic do_reset();
        env_on = 1'b0;
        reset = 1'b1;
        a_valid = 0; a_data = '0; b_req = 0; b_data = '0; b_last = 0;
        tx_busy = 0; tx_done_tick = 0; clr_err = 0; done_cnt = 0;
        aq.delete(); bq.delete(); txlog.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Expected order: A bytes and whole B packets alternate, A first after reset,
    // a lone remaining source takes every unit.
    task automatic run_env(input string tag, input int budget);
        logic [11:0] exp[$];
        logic [7:0]  a2[$];
        logic [8:0]  b2[$];
        bit          turn_a;
        bit          lst;
        int          n;
        a2 = aq;
        b2 = bq;
        turn_a = 1'b1;
        while (a2.size() > 0 || b2.size() > 0) begin
            if (a2.size() > 0 && (turn_a || b2.size() == 0)) begin
                exp.push_back({4'b1010, a2.pop_front()});
                turn_a = 1'b0;
            end else begin
                do begin
                    lst = b2[0][8];
                    exp.push_back({4'b0101, b2[0][7:0]});
                    void'(b2.pop_front());
                end while (!lst && b2.size() > 0);
                turn_a = 1'b1;
            end
        end
        env_on = 1'b1;
        env_sources();
        n = 0;
        while (txlog.size() < exp.size() && n < budget) begin
            tick();
            n++;
        end
        repeat (20) tick();
        check({tag, "_len"}, 32'(txlog.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < txlog.size()) check({tag, "_byte"}, 32'(txlog[i]), 32'(exp[i]));
        check({tag, "_noerr"}, 32'({err_timeout, err_abort}), 0);
        env_on = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("reset_outs", outs(), 0);
        tick();
        check("idle_outs", outs(), 0);

        // Echo only: N+1 latency, hold tx_data, one idle cycle after done
        do_reset();
        a_valid = 1; a_data = 8'h41;
        tick();
        check("echo_start", 32'({tx_start, a_pop, grant_a, b_ack}), 'b1110);
        check("echo_data", 32'(tx_data), 'h41);
        a_data = 8'h42;
        tick();
        check("echo_pulse_end", 32'({tx_start, a_pop}), 0);
        repeat (3) tick();
        check("echo_wait", 32'({tx_start, grant_a, tx_data}), 'h141);
        tx_done_tick = 1;
        tick();
        tx_done_tick = 0;
        check("echo_gap", 32'({tx_start, grant_a}), 0);
        tick();
        check("echo_next", 32'({tx_start, tx_data}), 'h142);

        // Tie after reset: A first, then the whole B packet uninterrupted
        do_reset();
        aq = '{8'h55, 8'h56};
        bq = '{9'h024, 9'h047, 9'h10D};
        run_env("tie", 2000);

        // Timeout: 50 WAIT_DONE cycles without done
        do_reset();
        a_valid = 1; a_data = 8'h11;
        tick();
        check("to_start", 32'(tx_start), 1);
        a_valid = 0;
        tick();
        repeat (49) tick();
        check("to_before", 32'({err_timeout, grant_a}), 'b01);
        tick();
        check("to_set", 32'({err_timeout, grant_a, grant_b, tx_start}), 'b1000);
        repeat (3) tick();
        check("to_sticky", 32'({err_timeout, tx_start}), 'b10);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("to_clr", 32'(err_timeout), 0);
        a_valid = 1; a_data = 8'h22;
        tick();
        check("to_idle", 32'({tx_start, tx_data}), 'h122);
        a_valid = 0;

        // Abort after byte 1 of 3, pending A granted the same cycle
        do_reset();
        b_req = 1; b_data = 8'h24; b_last = 0;
        tick();
        check("ab_b1", 32'({tx_start, b_ack, grant_b, a_pop, tx_data}), 'hE24);
        b_data = 8'h47;
        a_valid = 1; a_data = 8'h61;
        tick();
        tx_done_tick = 1;
        tick();
        tx_done_tick = 0;
        check("ab_lock_hold", 32'({grant_b, grant_a, tx_start}), 'b100);
        b_req = 0; clr_err = 1;
        tick();
        clr_err = 0;
        check("ab_err", 32'(err_abort), 1);
        check("ab_grant", 32'({grant_a, grant_b, tx_start, a_pop, b_ack}), 'b10110);
        check("ab_data", 32'(tx_data), 'h61);
        a_valid = 0;
        clr_err = 1;
        tick();
        clr_err = 0;
        check("ab_clr", 32'(err_abort), 0);

        // Reset in WAIT_DONE, then a stale done
        do_reset();
        a_valid = 1; a_data = 8'h77;
        tick();
        a_valid = 0;
        tick();
        tick();
        check("rst_pre", 32'({grant_a, tx_data}), 'h177);
        #2 reset = 1;
        #1;
        check("rst_async", outs(), 0);
        tick();
        reset = 0;
        tx_done_tick = 1;
        tick();
        tx_done_tick = 0;
        check("rst_stale", 32'({tx_start, grant_a, grant_b}), 0);
        repeat (3) tick();
        check("rst_quiet", outs(), 0);

        // tx_busy blocks selection
        do_reset();
        tx_busy = 1; a_valid = 1; a_data = 8'h09; b_req = 1; b_data = 8'h05; b_last = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("busy_hold", 32'({tx_start, grant_a, grant_b}), 0);
        end
        tx_busy = 0;
        tick();
        check("busy_go", 32'({tx_start, grant_a, tx_data}), 'h309);

        // Randomized traffic
        for (int r = 0; r < 4; r++) begin
            int na;
            int np;
            int len;
            do_reset();
            na = $urandom_range(2, 10);
            np = $urandom_range(1, 6);
            for (int i = 0; i < na; i++) aq.push_back(8'($urandom));
            for (int p = 0; p < np; p++) begin
                len = $urandom_range(1, 4);
                for (int k = 0; k < len; k++)
                    bq.push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
            end
            run_env("rand", 20000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: width of every data path.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum clk_50MHz cycles from tx_start to tx_done_tick.
REQ-003 SHALL have parameter TO_BITS, default 17: width of the timeout counter, with 2^TO_BITS > TIMEOUT_CYCLES.
REQ-004 SHALL have port clk_50MHz, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port a_valid, input, 1 bit: echo source has a byte, driven by FIFO not-empty.
REQ-007 SHALL have port a_data, input, DATA_BITS bits: echo byte at the FIFO head, stable until popped.
REQ-008 SHALL have port a_pop, output, 1 bit: one-cycle FIFO read pulse.
REQ-009 SHALL have port b_req, input, 1 bit: report source has a byte of a packet.
REQ-010 SHALL have port b_data, input, DATA_BITS bits: current report byte.
REQ-011 SHALL have port b_last, input, 1 bit: the current report byte is the final byte of its packet.
REQ-012 SHALL have port b_ack, output, 1 bit: one-cycle pulse; the report source advances to its next byte.
REQ-013 SHALL have port tx_start, output, 1 bit: one-cycle start pulse to the UART transmitter.
REQ-014 SHALL have port tx_data, output, DATA_BITS bits: byte to the transmitter, held from start until done.
REQ-015 SHALL have port tx_busy, input, 1 bit: transmitter busy.
REQ-016 SHALL have port tx_done_tick, input, 1 bit: transmitter finished a byte.
REQ-017 SHALL have port clr_err, input, 1 bit: synchronous clear of the sticky error flags.
REQ-018 SHALL have port grant_a, output, 1 bit: echo source currently owns the transmitter.
REQ-019 SHALL have port grant_b, output, 1 bit: report source currently owns the transmitter; grant_a and grant_b SHALL never both be 1.
REQ-020 SHALL have port err_timeout, output, 1 bit: sticky flag, set on a transmitter timeout.
REQ-021 SHALL have port err_abort, output, 1 bit: sticky flag, set on a report packet abort.

Function
REQ-022 SHALL use states IDLE, START and WAIT_DONE, and SHALL register all outputs.
REQ-023 IDLE with tx_busy=0 and at least one request SHALL select a winner, latch its data into tx_data, set the matching grant and enter START; tx_busy=1 SHALL block selection.
REQ-024 START SHALL last exactly one cycle, asserting tx_start plus a_pop (A winner) or b_ack (B winner), then enter WAIT_DONE.
REQ-025 Latency: a request sampled in IDLE at cycle N SHALL produce tx_start, pop or ack at cycle N+1.
REQ-026 WAIT_DONE SHALL count cycles from 0; on tx_done_tick it SHALL return to IDLE on the next cycle.
REQ-027 A grant SHALL cover one byte; a B grant SHALL cover a whole packet, from its first byte through the b_last byte (lock).
REQ-028 While B holds the lock, IDLE SHALL serve only B, ignoring a_valid.
REQ-029 Lock release SHALL occur on tx_done_tick of the b_last byte; grant_b SHALL fall with the return to IDLE.
REQ-030 Arbitration SHALL be round-robin per unit (A byte / B packet): with both requesting, the source not served last SHALL win; a single requester SHALL always win.
REQ-031 If the counter reaches TIMEOUT_CYCLES without tx_done_tick: set err_timeout, clear grants and lock, return to IDLE, and do not retry the byte.
REQ-032 If b_req=0 in IDLE while B holds the lock: set err_abort, release the lock, clear grant_b; A may be granted the same cycle.
REQ-033 tx_done_tick outside WAIT_DONE SHALL be ignored.
REQ-034 clr_err=1 SHALL clear both error flags; a set event in the same cycle SHALL win.
REQ-035 tx_data SHALL change only on entry to START.

Reset
REQ-036 Reset SHALL force IDLE, all outputs 0, tx_data 0, lock cleared, counter 0, last-served B (A wins the first tie), at any time including mid-transfer.

Verification
REQ-037 Echo only: a_valid=1, a_data=0x41 -> tx_start and a_pop pulse at N+1 with tx_data=0x41; next grant no earlier than 1 cycle after tx_done_tick.
REQ-038 Tie after reset: a_valid=1 and b_req=1 -> A served first, then a 3-byte B packet 0x24,0x47,0x0D (b_last on 0x0D) sent with no A byte interleaved.
REQ-039 Timeout: TIMEOUT_CYCLES=50, tx_done_tick never asserted -> err_timeout=1 at cycle 50 of WAIT_DONE, IDLE, grants 0; clr_err -> err_timeout=0.
REQ-040 Abort: b_req drops after byte 1 of 3 -> err_abort=1, lock released, pending A byte granted.
REQ-041 Reset asserted in WAIT_DONE -> all outputs 0 immediately; after release, a stale tx_done_tick causes no start.
REQ-042 tx_busy=1 with requests pending -> no tx_start until tx_busy=0.
